// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the SCAN elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR      = 2'd3
    } state_t;

    localparam int DEF_NUM_FLOORS    = 8;
    localparam int DEF_TRAVEL_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES   = 6;

    // Width of an index/counter covering 0..n-1, never below one bit.
    function automatic int fw_of(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevator_scan_ctrl_if.sv
// Call/door inputs and cab status outputs of the elevator controller.
interface elevator_scan_ctrl_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FW         = fw_of(NUM_FLOORS)
);
    logic [NUM_FLOORS-1:0] req;
    logic                  door_hold;
    logic [FW-1:0]         floor;
    logic                  motor_up;
    logic                  motor_down;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic                  busy;

    modport master (
        output req, door_hold,
        input  floor, motor_up, motor_down, door_open,
        input  pending, dir_up, busy
    );

    modport slave (
        input  req, door_hold,
        output floor, motor_up, motor_down, door_open,
        output pending, dir_up, busy
    );
endinterface

// File: rtl/elevator_req_latch.sv
// Outstanding-call register plus above/below/here queries.
module elevator_req_latch
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FW         = fw_of(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic                  clr_en,
    input  logic [FW-1:0]         clr_idx,
    input  logic [FW-1:0]         idx,
    input  logic [FW-1:0]         target,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  at_floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  t_at,
    output logic                  t_above,
    output logic                  t_below
);
    logic [NUM_FLOORS-1:0] clr;
    logic [NUM_FLOORS-1:0] merged;

    assign merged = pending | req;

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clr[i] = clr_en && (int'(clr_idx) == i);
        end
    end

    // Idle decisions look at latched calls only; arrival decisions
    // also see calls landing in the same cycle.
    always_comb begin
        at_floor  = 1'b0;
        any_above = 1'b0;
        any_below = 1'b0;
        t_at      = 1'b0;
        t_above   = 1'b0;
        t_below   = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i == int'(idx))    at_floor  = at_floor  | pending[i];
            if (i >  int'(idx))    any_above = any_above | pending[i];
            if (i <  int'(idx))    any_below = any_below | pending[i];
            if (i == int'(target)) t_at      = t_at      | merged[i];
            if (i >  int'(target)) t_above   = t_above   | merged[i];
            if (i <  int'(target)) t_below   = t_below   | merged[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= merged & ~clr;
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: Moore FSM with travel and door timers.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
    input logic                 clk,
    input logic                 reset,
    elevator_scan_ctrl_if.slave bus
);
    localparam int FW = fw_of(NUM_FLOORS);
    localparam int TW = fw_of(TRAVEL_CYCLES);
    localparam int DW = fw_of(DOOR_CYCLES);

    localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] D_LOAD = DW'(DOOR_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [FW-1:0]         floor_q;
    logic [FW-1:0]         floor_nxt;
    logic [FW-1:0]         target;
    logic [TW-1:0]         tcnt;
    logic [DW-1:0]         dcnt;
    logic                  dir_q;
    logic [NUM_FLOORS-1:0] pend;
    logic                  at_floor;
    logic                  any_above;
    logic                  any_below;
    logic                  t_at;
    logic                  t_above;
    logic                  t_below;
    logic                  moving;
    logic                  term;
    logic                  reload;
    logic                  clr_en;

    assign moving    = (state == S_MOVE_UP) || (state == S_MOVE_DOWN);
    assign term      = moving && (tcnt == T_LAST);
    assign target    = (state == S_MOVE_DOWN) ? floor_q - FW'(1)
                                              : floor_q + FW'(1);
    assign floor_nxt = term ? target : floor_q;
    assign reload    = bus.door_hold | bus.req[floor_q];
    assign clr_en    = (state_nxt == S_DOOR) || (state == S_DOOR);

    elevator_req_latch #(
        .NUM_FLOORS (NUM_FLOORS),
        .FW         (FW)
    ) u_latch (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.req),
        .clr_en    (clr_en),
        .clr_idx   (floor_nxt),
        .idx       (floor_q),
        .target    (target),
        .pending   (pend),
        .at_floor  (at_floor),
        .any_above (any_above),
        .any_below (any_below),
        .t_at      (t_at),
        .t_above   (t_above),
        .t_below   (t_below)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (at_floor)                state_nxt = S_DOOR;
                else if (dir_q && any_above) state_nxt = S_MOVE_UP;
                else if (!dir_q && any_below) state_nxt = S_MOVE_DOWN;
                else if (any_above)          state_nxt = S_MOVE_UP;
                else if (any_below)          state_nxt = S_MOVE_DOWN;
            end
            S_MOVE_UP: begin
                if (term) begin
                    if (t_at)         state_nxt = S_DOOR;
                    else if (t_above) state_nxt = S_MOVE_UP;
                    else              state_nxt = S_IDLE;
                end
            end
            S_MOVE_DOWN: begin
                if (term) begin
                    if (t_at)         state_nxt = S_DOOR;
                    else if (t_below) state_nxt = S_MOVE_DOWN;
                    else              state_nxt = S_IDLE;
                end
            end
            S_DOOR: begin
                if (!reload && dcnt == '0) state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            floor_q <= '0;
            dir_q   <= 1'b1;
            tcnt    <= '0;
            dcnt    <= '0;
        end else begin
            state   <= state_nxt;
            floor_q <= floor_nxt;
            if (state_nxt == S_MOVE_UP)        dir_q <= 1'b1;
            else if (state_nxt == S_MOVE_DOWN) dir_q <= 1'b0;
            if (moving) tcnt <= term ? '0 : tcnt + TW'(1);
            else        tcnt <= '0;
            // Door timer restarts on entry and on every hold/same-floor call.
            if (state_nxt == S_DOOR) begin
                if (state != S_DOOR || reload) dcnt <= D_LOAD;
                else                           dcnt <= dcnt - DW'(1);
            end else begin
                dcnt <= '0;
            end
        end
    end

    assign bus.floor      = floor_q;
    assign bus.motor_up   = (state == S_MOVE_UP);
    assign bus.motor_down = (state == S_MOVE_DOWN);
    assign bus.door_open  = (state == S_DOOR);
    assign bus.pending    = pend;
    assign bus.dir_up     = dir_q;
    assign bus.busy       = (state != S_IDLE) || (pend != '0);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench: expected door openings (floor, length) are queued.
module tb_elevator_scan_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    elevator_scan_ctrl_if #(.NUM_FLOORS(8)) bus ();

    elevator_scan_ctrl #(
        .NUM_FLOORS    (8),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int fl;
        int len;
    } door_t;

    door_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    logic  prev_door = 1'b0;
    int    run_len   = 0;
    int    run_floor = 0;

    // Each completed door opening is popped against the expected queue.
    always @(negedge clk) begin
        door_t e;
        if (reset) begin
            run_len = 0;
        end else if (bus.door_open) begin
            if (!prev_door) run_floor = int'(bus.floor);
            run_len++;
        end else if (prev_door) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL door_unexpected floor=%0d len=%0d need=none",
                         run_floor, run_len);
            end else begin
                e = exp_q.pop_front();
                if (run_floor !== e.fl || run_len !== e.len) begin
                    bad++;
                    $display("FAIL door_event got floor=%0d len=%0d need floor=%0d len=%0d",
                             run_floor, run_len, e.fl, e.len);
                end
            end
            run_len = 0;
        end
        prev_door = reset ? 1'b0 : bus.door_open;
    end

    task automatic pulse(input logic [7:0] v);
        @(negedge clk) bus.req = v;
        @(negedge clk) bus.req = 8'h00;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((bus.busy || bus.door_open) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.busy || bus.door_open) begin
            bad++;
            $display("FAIL %s_timeout busy=%0b need=0", name, bus.busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_door(input string name);
        for (int i = 0; i < 20; i++) begin
            if (bus.door_open) break;
            @(negedge clk);
        end
        total++;
        if (bus.door_open !== 1'b1) begin
            bad++;
            $display("FAIL %s_door_wait got=%0b need=1", name, bus.door_open);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total += 6;
        if (bus.floor !== 3'd0) begin
            bad++; $display("FAIL rst_floor got=%0d need=0", bus.floor);
        end
        if (bus.pending !== 8'h00) begin
            bad++; $display("FAIL rst_pending got=%h need=00", bus.pending);
        end
        if (bus.motor_up !== 1'b0 || bus.motor_down !== 1'b0) begin
            bad++; $display("FAIL rst_motor got=%b%b need=00", bus.motor_up, bus.motor_down);
        end
        if (bus.door_open !== 1'b0) begin
            bad++; $display("FAIL rst_door got=%b need=0", bus.door_open);
        end
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy got=%b need=0", bus.busy);
        end
        if (bus.dir_up !== 1'b1) begin
            bad++; $display("FAIL rst_dir got=%b need=1", bus.dir_up);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_door();
        exp_q.push_back('{0, 6});
        pulse(8'h01);
        total++;
        if (bus.door_open !== 1'b0) begin
            bad++; $display("FAIL single_early got=%b need=0", bus.door_open);
        end
        @(negedge clk);
        total++;
        if (bus.door_open !== 1'b1) begin
            bad++; $display("FAIL single_latency got=%b need=1", bus.door_open);
        end
        wait_idle(50, "single");
        total += 2;
        if (bus.pending !== 8'h00) begin
            bad++; $display("FAIL single_pending got=%h need=00", bus.pending);
        end
        if (bus.floor !== 3'd0) begin
            bad++; $display("FAIL single_floor got=%0d need=0", bus.floor);
        end
    endtask

    task automatic test_travel_up();
        int mu;
        int md;
        int last;
        logic mono;
        mu = 0; md = 0; mono = 1'b1;
        exp_q.push_back('{5, 6});
        pulse(8'h20);
        last = int'(bus.floor);
        for (int i = 0; i < 200 && (bus.busy || bus.door_open); i++) begin
            if (bus.motor_up) mu++;
            if (bus.motor_down) md++;
            if (int'(bus.floor) != last && int'(bus.floor) != last + 1) mono = 1'b0;
            last = int'(bus.floor);
            @(negedge clk);
        end
        total += 5;
        if (mu !== 20) begin
            bad++; $display("FAIL up_motor_cycles got=%0d need=20", mu);
        end
        if (md !== 0) begin
            bad++; $display("FAIL up_motor_down got=%0d need=0", md);
        end
        if (mono !== 1'b1) begin
            bad++; $display("FAIL up_floor_step got=%b need=1", mono);
        end
        if (bus.floor !== 3'd5) begin
            bad++; $display("FAIL up_floor got=%0d need=5", bus.floor);
        end
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL up_busy got=%b need=0", bus.busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_scan_order();
        exp_q.push_back('{3, 6});
        pulse(8'h08);
        wait_idle(200, "scan_pre");
        exp_q.push_back('{5, 6});
        exp_q.push_back('{6, 6});
        exp_q.push_back('{1, 6});
        pulse(8'h40);
        for (int i = 0; i < 20; i++) begin
            if (bus.motor_up) break;
            @(negedge clk);
        end
        total++;
        if (bus.motor_up !== 1'b1 || bus.floor !== 3'd3) begin
            bad++;
            $display("FAIL scan_start got up=%b floor=%0d need up=1 floor=3",
                     bus.motor_up, bus.floor);
        end
        pulse(8'h22);
        wait_idle(400, "scan");
        total += 3;
        if (bus.floor !== 3'd1) begin
            bad++; $display("FAIL scan_floor got=%0d need=1", bus.floor);
        end
        if (bus.dir_up !== 1'b0) begin
            bad++; $display("FAIL scan_dir got=%b need=0", bus.dir_up);
        end
        if (bus.pending !== 8'h00) begin
            bad++; $display("FAIL scan_pending got=%h need=00", bus.pending);
        end
    endtask

    task automatic test_door_hold();
        int cnt;
        exp_q.push_back('{1, 17});
        pulse(8'h02);
        wait_door("hold");
        @(negedge clk) bus.door_hold = 1'b1;
        repeat (10) @(negedge clk);
        bus.door_hold = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.door_open) break;
            cnt++;
            @(negedge clk);
        end
        total++;
        if (cnt !== 6) begin
            bad++; $display("FAIL hold_tail got=%0d need=6", cnt);
        end
        wait_idle(50, "hold");
    endtask

    task automatic test_door_reload();
        exp_q.push_back('{1, 9});
        pulse(8'h02);
        wait_door("reload");
        @(negedge clk);
        @(negedge clk) bus.req = 8'h02;
        @(negedge clk) bus.req = 8'h00;
        total += 2;
        if (bus.pending !== 8'h00) begin
            bad++; $display("FAIL reload_pending got=%h need=00", bus.pending);
        end
        if (bus.door_open !== 1'b1) begin
            bad++; $display("FAIL reload_door got=%b need=1", bus.door_open);
        end
        wait_idle(50, "reload");
    endtask

    task automatic test_boundary();
        exp_q.push_back('{7, 6});
        pulse(8'h80);
        wait_idle(400, "top");
        total++;
        if (bus.floor !== 3'd7) begin
            bad++; $display("FAIL top_floor got=%0d need=7", bus.floor);
        end
        exp_q.push_back('{0, 6});
        pulse(8'h01);
        wait_idle(400, "bottom");
        total += 2;
        if (bus.floor !== 3'd0) begin
            bad++; $display("FAIL bottom_floor got=%0d need=0", bus.floor);
        end
        if (bus.dir_up !== 1'b0) begin
            bad++; $display("FAIL bottom_dir got=%b need=0", bus.dir_up);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back('{0, 6});
        exp_q.push_back('{2, 6});
        pulse(8'h05);
        wait_idle(200, "b2b");
        total++;
        if (bus.floor !== 3'd2) begin
            bad++; $display("FAIL b2b_floor got=%0d need=2", bus.floor);
        end
    endtask

    task automatic test_reset_midtravel();
        test_reset();
        pulse(8'h80);
        for (int i = 0; i < 60; i++) begin
            if (bus.motor_up && bus.floor == 3'd2) break;
            @(negedge clk);
        end
        total++;
        if (bus.motor_up !== 1'b1 || bus.floor !== 3'd2) begin
            bad++;
            $display("FAIL mid_reach got up=%b floor=%0d need up=1 floor=2",
                     bus.motor_up, bus.floor);
        end
        reset  = 1'b1;
        bus.req = 8'h01;
        @(negedge clk);
        total += 4;
        if (bus.floor !== 3'd0) begin
            bad++; $display("FAIL mid_floor got=%0d need=0", bus.floor);
        end
        if (bus.motor_up !== 1'b0 || bus.motor_down !== 1'b0) begin
            bad++; $display("FAIL mid_motor got=%b%b need=00", bus.motor_up, bus.motor_down);
        end
        if (bus.pending !== 8'h00) begin
            bad++; $display("FAIL mid_pending got=%h need=00", bus.pending);
        end
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL mid_busy got=%b need=0", bus.busy);
        end
        reset   = 1'b0;
        bus.req = 8'h00;
        repeat (4) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.door_open !== 1'b0) begin
            bad++; $display("FAIL mid_discard got busy=%b door=%b need 0 0",
                            bus.busy, bus.door_open);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.req       = 8'h00;
        bus.door_hold = 1'b0;
        test_reset();
        test_single_door();
        test_travel_up();
        test_scan_order();
        test_door_hold();
        test_door_reload();
        test_boundary();
        test_back_to_back();
        test_reset_midtravel();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL door_missing left=%0d need=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
